// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache store port: FSM states, the line record,
// address-split widths and the store-size codes.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

package dcache_pkg;

  localparam int DC_N_LINES    = 4;
  localparam int DC_LINE_BYTES = 16;
  localparam int DC_WORD_SIZE  = `WORD_SIZE;
  localparam int DC_WIDTH      = `ADDRESS_WIDTH;
  localparam int DC_SIZE_W     = `SIZE_WRITE_WIDTH;

  localparam int OFFSET_W       = $clog2(DC_LINE_BYTES);
  localparam int INDEX_W        = $clog2(DC_N_LINES);
  localparam int TAG_W          = DC_WIDTH - OFFSET_W - INDEX_W;
  localparam int LINE_W         = DC_LINE_BYTES * 8;
  localparam int WORD_BYTES     = DC_WORD_SIZE / 8;
  localparam int LANE_W         = $clog2(WORD_BYTES);
  localparam int WORDS_PER_LINE = DC_LINE_BYTES / WORD_BYTES;
  localparam int WORD_SEL_W     = $clog2(WORDS_PER_LINE);

  localparam logic [DC_SIZE_W-1:0] SIZE_BYTE = `BYTE_SIZE;
  localparam logic [DC_SIZE_W-1:0] SIZE_WORD = `FULL_WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic size_supported(input logic [DC_SIZE_W-1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_WORD);
  endfunction

endpackage

// File: rtl/dcache_store_port_if.sv
// Line-granular memory request/response bus between the cache and the next memory level.
interface dcache_store_port_if #(
  parameter int WIDTH      = 32,
  parameter int LINE_BYTES = 16
);

  logic                    mem_req_valid;
  logic                    mem_req_we;
  logic [WIDTH-1:0]        mem_req_addr;
  logic [LINE_BYTES*8-1:0] mem_req_wdata;
  logic                    mem_req_ready;
  logic                    mem_resp_valid;
  logic [LINE_BYTES*8-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_we,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_we,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped line storage: combinational read of one line, byte-lane store write,
// whole-line fill and victim dirty-clear, all committed at the clock edge.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter logic [LINE_W-1:0] INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_W-1:0]      rd_index,
  output line_t                   rd_line,
  input  logic                    st_en,
  input  logic [INDEX_W-1:0]      st_index,
  input  logic [WORD_SEL_W-1:0]   st_word,
  input  logic [WORD_BYTES-1:0]   st_byte_en,
  input  logic [DC_WORD_SIZE-1:0] st_data,
  input  logic                    clr_dirty_en,
  input  logic [INDEX_W-1:0]      clr_index,
  input  logic                    fill_en,
  input  logic [INDEX_W-1:0]      fill_index,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [LINE_W-1:0]       fill_data
);

  logic              valid_q [DC_N_LINES];
  logic              valid_d [DC_N_LINES];
  logic              dirty_q [DC_N_LINES];
  logic              dirty_d [DC_N_LINES];
  logic [TAG_W-1:0]  tag_q   [DC_N_LINES];
  logic [TAG_W-1:0]  tag_d   [DC_N_LINES];
  logic [LINE_W-1:0] data_q  [DC_N_LINES];
  logic [LINE_W-1:0] data_d  [DC_N_LINES];

  always_comb begin
    rd_line.valid = valid_q[rd_index];
    rd_line.dirty = dirty_q[rd_index];
    rd_line.tag   = tag_q[rd_index];
    rd_line.data  = data_q[rd_index];
  end

  // Store is applied last so a store never loses to a same-cycle bookkeeping update.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr_dirty_en) begin
      dirty_d[clr_index] = 1'b0;
    end
    if (fill_en) begin
      valid_d[fill_index] = 1'b1;
      dirty_d[fill_index] = 1'b0;
      tag_d[fill_index]   = fill_tag;
      data_d[fill_index]  = fill_data;
    end
    if (st_en) begin
      dirty_d[st_index] = 1'b1;
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (st_byte_en[b]) begin
          data_d[st_index][st_word*DC_WORD_SIZE + b*8 +: 8] = st_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DC_N_LINES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= INIT[TAG_W-1:0];
        data_q[i]  <= INIT;
      end
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dcache_store_port.sv
// Write-back, write-allocate store port: commits store-buffer head on a hit, otherwise
// evicts a dirty victim and refills the line before letting the store hit.
module dcache_store_port
  import dcache_pkg::*;
#(
  parameter int                N_LINES          = DC_N_LINES,
  parameter int                LINE_BYTES       = DC_LINE_BYTES,
  parameter int                WORD_SIZE        = DC_WORD_SIZE,
  parameter int                WIDTH            = DC_WIDTH,
  parameter int                SIZE_WRITE_WIDTH = DC_SIZE_W,
  parameter logic [LINE_W-1:0] INIT             = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cache_wenable,
  input  logic [WIDTH-1:0]            cache_physical_address,
  input  logic [WORD_SIZE-1:0]        cache_store_value,
  input  logic [SIZE_WRITE_WIDTH-1:0] cache_store_size,
  output logic                        store_success,
  dcache_store_port_if.master         mem
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(N_LINES);
  localparam logic [OFF_W-1:0] OFF_ZERO = '0;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;

  assign offset = cache_physical_address[OFF_W-1:0];
  assign index  = cache_physical_address[OFF_W +: IDX_W];
  assign tag    = cache_physical_address[WIDTH-1:OFF_W+IDX_W];

  state_t                   state_q, state_d;
  logic                     req_valid_q, req_valid_d;
  logic                     req_we_q, req_we_d;
  logic [WIDTH-1:0]         req_addr_q, req_addr_d;
  logic [LINE_W-1:0]        req_wdata_q, req_wdata_d;
  logic [TAG_W+IDX_W-1:0]   miss_line_q, miss_line_d;

  line_t                    cur_line;
  logic                     hit;
  logic                     size_ok;
  logic                     store_hit;
  logic                     clr_dirty;
  logic                     fill_en;
  logic [WORD_BYTES-1:0]    st_byte_en;
  logic [WORD_SIZE-1:0]     st_data;

  assign hit     = cur_line.valid && (cur_line.tag == tag);
  assign size_ok = size_supported(cache_store_size);

  // Byte stores replicate the low byte to every lane; the enable picks the one that lands.
  always_comb begin
    st_data = (cache_store_size == SIZE_WORD) ? cache_store_value
                                              : {WORD_BYTES{cache_store_value[7:0]}};
    for (int l = 0; l < WORD_BYTES; l++) begin
      st_byte_en[l] = (cache_store_size == SIZE_WORD) || (offset[LANE_W-1:0] == LANE_W'(l));
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    miss_line_d = miss_line_q;
    store_hit   = 1'b0;
    clr_dirty   = 1'b0;
    fill_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cache_wenable && size_ok) begin
          if (hit) begin
            store_hit = 1'b1;
          end else begin
            miss_line_d = {tag, index};
            req_valid_d = 1'b1;
            if (cur_line.valid && cur_line.dirty) begin
              state_d     = WB_REQ;
              req_we_d    = 1'b1;
              req_addr_d  = {cur_line.tag, index, OFF_ZERO};
              req_wdata_d = cur_line.data;
            end else begin
              state_d    = FILL_REQ;
              req_we_d   = 1'b0;
              req_addr_d = {tag, index, OFF_ZERO};
            end
          end
        end
      end
      WB_REQ: begin
        if (mem.mem_req_ready) begin
          state_d    = FILL_REQ;
          clr_dirty  = 1'b1;
          req_we_d   = 1'b0;
          req_addr_d = {miss_line_q, OFF_ZERO};
        end
      end
      FILL_REQ: begin
        if (mem.mem_req_ready) begin
          state_d     = FILL_WAIT;
          req_valid_d = 1'b0;
        end
      end
      FILL_WAIT: begin
        if (mem.mem_resp_valid) begin
          state_d = IDLE;
          fill_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      miss_line_q <= miss_line_d;
    end
  end

  assign store_success     = store_hit && !rst;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = req_we_q;
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;

  dcache_line_array #(
    .INIT(INIT)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (index),
    .rd_line      (cur_line),
    .st_en        (store_success),
    .st_index     (index),
    .st_word      (offset[OFF_W-1:LANE_W]),
    .st_byte_en   (st_byte_en),
    .st_data      (st_data),
    .clr_dirty_en (clr_dirty),
    .clr_index    (miss_line_q[IDX_W-1:0]),
    .fill_en      (fill_en),
    .fill_index   (miss_line_q[IDX_W-1:0]),
    .fill_tag     (miss_line_q[TAG_W+IDX_W-1:IDX_W]),
    .fill_data    (mem.mem_resp_rdata)
  );

  // Unsupported size codes stall the store buffer forever, so flag them.
  a_size_supported: assert property (@(posedge clk) disable iff (rst)
    (cache_wenable && state_q == IDLE) |-> size_ok);

endmodule
